// File: rtl/demux1to16_frame.sv
// -----------------------------------------------------------------------------
// demux1to16_frame
//   Sequential 1-to-16 demultiplexer / deserializer. Each accepted serial bit
//   is steered into one slot of a 16-bit shadow frame. The slot comes either
//   from the explicit select s or from an internal auto-increment pointer.
//   The finished frame is published on w together with a one-cycle strobe.
//   w never exposes a partially filled frame.
//
// Optional build macro:
//   DEMUX_MSB_FIRST_EN - auto mode fills slots 15 down to 0. The pointer
//                        starts at 15, decrements per auto beat and reloads
//                        to 15. Explicit-select mode is not affected.
//
// Ports:
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   d_in        in   serial data bit
//   d_valid     in   beat qualifier for d_in
//   s[3:0]      in   explicit slot select (used when auto_mode=0)
//   auto_mode   in   1: slot from internal pointer, 0: slot from s
//   clr         in   synchronous abort of the frame in progress
//   w[15:0]     out  last completed frame (held until next completion)
//   word_valid  out  one-cycle strobe, w was just updated
//   busy        out  partial frame held (state FILL)
//   ptr[3:0]    out  current auto pointer
//   overrun     out  sticky, a slot was written twice within one frame
// -----------------------------------------------------------------------------
module demux1to16_frame #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic [3:0]       s,
    input  logic             auto_mode,
    input  logic             clr,
    output logic [WIDTH-1:0] w,
    output logic             word_valid,
    output logic             busy,
    output logic [3:0]       ptr,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef DEMUX_MSB_FIRST_EN
    localparam logic [3:0] PTR_INIT = 4'd15;
`else
    localparam logic [3:0] PTR_INIT = 4'd0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             word_valid_q, word_valid_d;
    logic [3:0]       ptr_q, ptr_d;
    logic             overrun_q, overrun_d;

    // Beat-level helper signals
    logic             accept;
    logic [3:0]       idx;
    logic             dup;
    logic [WIDTH-1:0] mask_set;
    logic [WIDTH-1:0] shadow_set;
    logic             complete;
    logic [3:0]       ptr_step;

    always_comb begin
        // clr takes priority: a beat in the same cycle is simply dropped
        accept     = d_valid & ~clr;
        idx        = auto_mode ? ptr_q : s;
        dup        = mask_q[idx];
        mask_set   = mask_q;
        mask_set[idx] = 1'b1;
        shadow_set = shadow_q;
        shadow_set[idx] = d_in;
        // A duplicate leaves mask_set == mask_q, which is never full here
        // (completion clears the mask), so duplicates cannot complete.
        complete   = accept & (&mask_set);
`ifdef DEMUX_MSB_FIRST_EN
        ptr_step   = ptr_q - 4'd1;
`else
        ptr_step   = ptr_q + 4'd1;
`endif
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        w_d          = w_q;
        word_valid_d = 1'b0;
        ptr_d        = ptr_q;
        overrun_d    = overrun_q;

        if (clr) begin
            // shadow and w intentionally untouched
            mask_d    = '0;
            ptr_d     = PTR_INIT;
            overrun_d = 1'b0;
            state_d   = IDLE;
        end else if (accept) begin
            shadow_d = shadow_set;
            if (dup) begin
                overrun_d = 1'b1;
            end
            if (auto_mode) begin
                ptr_d = ptr_step;
            end
            if (complete) begin
                w_d          = shadow_set;
                word_valid_d = 1'b1;
                mask_d       = '0;
                ptr_d        = PTR_INIT;
                state_d      = DONE;
            end else begin
                mask_d  = mask_set;
                state_d = FILL;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            mask_q       <= '0;
            w_q          <= '0;
            word_valid_q <= 1'b0;
            ptr_q        <= PTR_INIT;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            w_q          <= w_d;
            word_valid_q <= word_valid_d;
            ptr_q        <= ptr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign w          = w_q;
    assign word_valid = word_valid_q;
    assign busy       = (state_q == FILL);
    assign ptr        = ptr_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux1to16_frame.sv
module tb_demux1to16_frame;

    logic        clk = 1'b0;
    logic        resetn;
    logic        d_in;
    logic        d_valid;
    logic [3:0]  s;
    logic        auto_mode;
    logic        clr;
    logic [15:0] w;
    logic        word_valid;
    logic        busy;
    logic [3:0]  ptr;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DEMUX_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    demux1to16_frame dut (
        .clk        (clk),
        .resetn     (resetn),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .s          (s),
        .auto_mode  (auto_mode),
        .clr        (clr),
        .w          (w),
        .word_valid (word_valid),
        .busy       (busy),
        .ptr        (ptr),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic a, input logic [3:0] sel);
        d_in      = d;
        auto_mode = a;
        s         = sel;
        d_valid   = 1'b1;
        tick();
        d_valid   = 1'b0;
    endtask

    // Expected slot/pointer after n auto beats from the initial pointer
    function automatic logic [3:0] ptr_after(input int n);
        logic [3:0] v;
        v = 4'(n);
        return MSB_FIRST ? 4'd15 - v : v;
    endfunction

    // Bit carried by auto beat i for frame value v
    function automatic logic auto_bit(input logic [15:0] v, input int i);
        return v[ptr_after(i)];
    endfunction

    logic [3:0]  perm [16];
    logic [15:0] val;
    int          pulse_cyc [$];
    int          cyc;

    initial begin
        perm = '{4'd15, 4'd0, 4'd7, 4'd3, 4'd12, 4'd1, 4'd9, 4'd5,
                 4'd14, 4'd2, 4'd11, 4'd6, 4'd13, 4'd4, 4'd10, 4'd8};
        resetn = 1'b0; d_in = 1'b0; d_valid = 1'b0; s = 4'd0;
        auto_mode = 1'b0; clr = 1'b0;
        repeat (2) tick();
        check("rst_w", w, 16'h0);
        check("rst_wv", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr", ptr, ptr_after(0));
        check("rst_ovr", overrun, 0);
        resetn = 1'b1;
        tick();

        // Auto fill of 0xA5C3
        val = 16'hA5C3;
        for (int i = 0; i < 15; i++) beat(auto_bit(val, i), 1'b1, 4'd0);
        check("auto_busy_mid", busy, 1);
        check("auto_wv_mid", word_valid, 0);
        check("auto_w_mid", w, 16'h0);
        beat(auto_bit(val, 15), 1'b1, 4'd0);
        check("auto_w", w, 16'hA5C3);
        check("auto_wv", word_valid, 1);
        check("auto_ptr", ptr, ptr_after(0));
        check("auto_busy", busy, 0);
        check("auto_ovr", overrun, 0);
        tick();
        check("auto_wv_drop", word_valid, 0);
        check("auto_w_hold", w, 16'hA5C3);

        // Explicit scatter of 0x8001
        val = 16'h8001;
        for (int i = 0; i < 15; i++) beat(val[perm[i]], 1'b0, perm[i]);
        check("expl_w_mid", w, 16'hA5C3);
        check("expl_busy_mid", busy, 1);
        check("expl_wv_mid", word_valid, 0);
        check("expl_ptr_mid", ptr, ptr_after(0));
        beat(val[perm[15]], 1'b0, perm[15]);
        check("expl_w", w, 16'h8001);
        check("expl_wv", word_valid, 1);
        tick();
        check("expl_wv_drop", word_valid, 0);

        // clr mid-frame, beat in same cycle discarded
        for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, 4'd0);
        check("clr_ptr8", ptr, ptr_after(8));
        check("clr_busy8", busy, 1);
        clr = 1'b1; d_in = 1'b1; d_valid = 1'b1; auto_mode = 1'b1;
        tick();
        clr = 1'b0; d_valid = 1'b0;
        check("clr_ptr", ptr, ptr_after(0));
        check("clr_busy", busy, 0);
        check("clr_ovr", overrun, 0);
        check("clr_w", w, 16'h8001);
        check("clr_wv", word_valid, 0);
        for (int i = 0; i < 15; i++) beat(1'b1, 1'b1, 4'd0);
        check("ffff_wv_mid", word_valid, 0);
        beat(1'b1, 1'b1, 4'd0);
        check("ffff_w", w, 16'hFFFF);
        check("ffff_wv", word_valid, 1);
        check("ffff_ovr", overrun, 0);
        tick();

        // Duplicate write and overrun
        beat(1'b1, 1'b0, 4'd3);
        check("dup_ovr0", overrun, 0);
        beat(1'b0, 1'b0, 4'd3);
        check("dup_ovr1", overrun, 1);
        check("dup_busy", busy, 1);
        for (int i = 0; i < 14; i++) beat(1'b0, 1'b0, (i < 3) ? 4'(i) : 4'(i + 1));
        check("dup_wv_mid", word_valid, 0);
        beat(1'b0, 1'b0, 4'd15);
        check("dup_w", w, 16'h0000);
        check("dup_wv", word_valid, 1);
        check("dup_ovr_done", overrun, 1);
        tick();
        check("dup_ovr_sticky", overrun, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("dup_ovr_clr", overrun, 0);

        // Back-to-back auto frames 0x1234 then 0xFFFF
        cyc = 0;
        for (int f = 0; f < 2; f++) begin
            val = (f == 0) ? 16'h1234 : 16'hFFFF;
            for (int i = 0; i < 16; i++) begin
                beat(auto_bit(val, i), 1'b1, 4'd0);
                cyc++;
                if (word_valid) begin
                    pulse_cyc.push_back(cyc);
                    check($sformatf("b2b_w%0d", pulse_cyc.size()), w,
                          (pulse_cyc.size() == 1) ? 16'h1234 : 16'hFFFF);
                end
            end
        end
        check("b2b_pulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) begin
            check("b2b_first", pulse_cyc[0], 16);
            check("b2b_gap", pulse_cyc[1] - pulse_cyc[0], 16);
        end

        // Third frame aborted by async reset
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 4'd0);
        check("arst_busy_pre", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_w", w, 16'h0);
        check("arst_wv", word_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ptr", ptr, ptr_after(0));
        check("arst_ovr", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1to16_frame.md
Name: demux1to16_frame

Overview:
- Sequential 1-to-16 demultiplexer and deserializer. It is the receive-side counterpart of the team's 16:1 bit-select mux tree.
- Accepts a serial bit stream, one bit per valid beat, and steers each bit to a slot of a 16-bit frame. Slot is either an explicit 4-bit select or an internal auto-increment pointer.
- Presents the completed frame on a stable parallel output with a one-cycle completion strobe.
- Sits downstream of the mux tree to rebuild 16-bit words sent bit-by-bit.

Parameters:
- WIDTH, 16, frame width in bits. Fixed at 16; select and pointer are 4 bits.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- d_in  in  1  serial data bit.
- d_valid  in  1  beat qualifier; d_in is accepted on a rising edge when d_valid=1.
- s  in  4  explicit slot select, used when auto_mode=0.
- auto_mode  in  1  1 = slot taken from the internal pointer; 0 = slot taken from s. Sampled per beat.
- clr  in  1  synchronous abort of the frame in progress.
- w  out  16  last completed frame. Registered; holds its value until the next completion.
- word_valid  out  1  one-cycle strobe: w was just updated.
- busy  out  1  1 while a partial frame is held (state FILL).
- ptr  out  4  current auto-increment pointer.
- overrun  out  1  sticky: a slot was written twice within one frame.

Behaviour:
- Reset (resetn=0, async): w=0, word_valid=0, busy=0, ptr=0, overrun=0, internal shadow=0, fill mask=0, state=IDLE.
- Internal storage:
  - shadow[15:0] collects bits.
  - mask[15:0] marks the slots written in the current frame.
  - w is loaded only at frame completion.
- Slot index on a beat: idx = auto_mode ? ptr : s.
- Accepted beat:
  - shadow[idx] <= d_in; mask[idx] <= 1.
  - If auto_mode=1, ptr <= ptr+1, mod 16: 15 wraps to 0.
- Duplicate write (mask[idx] already 1, normally only in explicit mode):
  - Bit is overwritten.
  - overrun <= 1, sticky until clr or reset.
  - Does not count toward completion.
- Completion: the accepted beat that makes mask all-ones. On that same edge:
  - w <= shadow with the new bit merged.
  - word_valid <= 1 for exactly the following cycle.
  - mask <= 0, ptr <= 0.
  - State goes to DONE.
- Latency: the 16th distinct slot is written on edge N; w and word_valid are visible in cycle N+1.
- FSM:
  - IDLE: mask=0. Accepted beat -> FILL.
  - FILL: busy=1. Completing beat -> DONE. clr -> IDLE.
  - DONE: word_valid=1, one cycle only.
    - A beat in this cycle is accepted as the first beat of the next frame -> FILL.
    - No beat -> IDLE.
    - Back-to-back frames need no idle cycles.
- clr (synchronous):
  - Sets mask=0, ptr=0, overrun=0, state=IDLE.
  - shadow and w are left unchanged.
  - If clr and d_valid occur in the same cycle, clr wins and the beat is discarded.
  - If clr occurs in DONE, word_valid still completes its single cycle.
- Mixed modes within a frame are legal.
  - ptr advances only on auto beats.
  - Explicit beats may collide with later auto slots; the overrun rule applies.
- Asserting resetn low mid-frame discards the partial frame immediately.
- w never shows a partial frame.

Optional Feature:
- Macro: DEMUX_MSB_FIRST_EN.
- Defined:
  - Auto mode fills slots 15 down to 0.
  - ptr resets and reloads to 15, and decrements per auto beat (0 wraps to 15).
  - ptr returns to 15 at completion and on clr.
- Undefined: LSB-first fill as described above (ptr starts at 0 and increments).
- Explicit-select mode is unaffected either way.

Test Plan:
- Auto LSB-first fill: reset; auto_mode=1; 16 back-to-back beats carrying 0xA5C3 bit0 first.
  - After the 16th edge: w=0xA5C3, word_valid=1 for one cycle, ptr=0, busy=0, overrun=0.
- Explicit scatter: auto_mode=0; beats at s=15,0,7,…, a permutation of all 16 slots, carrying 0x8001.
  - Expected: w=0x8001 with a single word_valid pulse.
  - Before completion: w still holds the prior value and busy=1.
- Duplicate and overrun: explicit beats to s=3 twice (d=1 then d=0), then the remaining 15 slots with 0.
  - Expected: overrun=1 after the second beat; completion after 17 beats total; w=0x0000; overrun stays 1 until clr.
- clr mid-frame: auto 8 beats, then clr together with d_valid=1.
  - Expected: beat discarded; ptr=0, busy=0, overrun=0; w unchanged.
  - A following full 16-beat frame of 0xFFFF yields w=0xFFFF.
- Back-to-back with async reset: two consecutive auto frames with no gap, 0x1234 then 0xFFFF.
  - Expected: two word_valid pulses exactly 16 cycles apart.
  - Pull resetn low 5 beats into a third frame: all outputs return to 0 immediately.
- With DEMUX_MSB_FIRST_EN defined: 16 auto beats of 0xA5C3 sent bit15 first.
  - Expected: w=0xA5C3; ptr reads 15 after reset and after completion.
